// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared state encoding, sensor patterns and width helper
package parking_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_EN_A  = 3'd1,
    ST_EN_AB = 3'd2,
    ST_EN_B  = 3'd3,
    ST_EX_B  = 3'd4,
    ST_EX_BA = 3'd5,
    ST_EX_A  = 3'd6
  } gate_state_t;

  // Sensor patterns as {a, b}: a is the outer beam, b the inner one.
  localparam logic [1:0] AB_NONE = 2'b00;
  localparam logic [1:0] AB_B    = 2'b01;
  localparam logic [1:0] AB_A    = 2'b10;
  localparam logic [1:0] AB_BOTH = 2'b11;

  function automatic int bits_for(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/gate_dir_fsm.sv
// rtl/gate_dir_fsm.sv - one gate's direction classifier with stuck-sequence timeout
module gate_dir_fsm
  import parking_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic a,
  input  logic b,
  output logic enter_next,
  output logic exit_next,
  output logic err_next
);

  localparam int TMR_W = bits_for(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  gate_state_t      state;
  gate_state_t      fsm_nxt;
  gate_state_t      state_nxt;
  logic [TMR_W-1:0] timer;
  logic [1:0]       ab;
  logic             fault;
  logic             tmo;

  assign ab = {a, b};

  always_comb begin
    fsm_nxt    = state;
    enter_next = 1'b0;
    exit_next  = 1'b0;
    fault      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ab == AB_A)      fsm_nxt = ST_EN_A;
        else if (ab == AB_B) fsm_nxt = ST_EX_B;
      end
      ST_EN_A: begin
        if (ab == AB_BOTH)      fsm_nxt = ST_EN_AB;
        else if (ab == AB_NONE) fsm_nxt = ST_IDLE;
        else if (ab == AB_B) begin fsm_nxt = ST_IDLE; fault = 1'b1; end
      end
      ST_EN_AB: begin
        if (ab == AB_B)         fsm_nxt = ST_EN_B;
        else if (ab == AB_A)    fsm_nxt = ST_EN_A;
        else if (ab == AB_NONE) begin fsm_nxt = ST_IDLE; fault = 1'b1; end
      end
      ST_EN_B: begin
        if (ab == AB_NONE)      begin fsm_nxt = ST_IDLE; enter_next = 1'b1; end
        else if (ab == AB_BOTH) fsm_nxt = ST_EN_AB;
        else if (ab == AB_A)    begin fsm_nxt = ST_IDLE; fault = 1'b1; end
      end
      ST_EX_B: begin
        if (ab == AB_BOTH)      fsm_nxt = ST_EX_BA;
        else if (ab == AB_NONE) fsm_nxt = ST_IDLE;
        else if (ab == AB_A)    begin fsm_nxt = ST_IDLE; fault = 1'b1; end
      end
      ST_EX_BA: begin
        if (ab == AB_A)         fsm_nxt = ST_EX_A;
        else if (ab == AB_B)    fsm_nxt = ST_EX_B;
        else if (ab == AB_NONE) begin fsm_nxt = ST_IDLE; fault = 1'b1; end
      end
      ST_EX_A: begin
        if (ab == AB_NONE)      begin fsm_nxt = ST_IDLE; exit_next = 1'b1; end
        else if (ab == AB_BOTH) fsm_nxt = ST_EX_BA;
        else if (ab == AB_B)    begin fsm_nxt = ST_IDLE; fault = 1'b1; end
      end
      default: fsm_nxt = ST_IDLE;
    endcase
  end

  // Timeout only applies when the sensors would otherwise leave the state alone.
  assign tmo = (TIMEOUT_CYCLES != 0) && (state != ST_IDLE) &&
               (fsm_nxt == state) && (timer == TMO_LAST);

  always_comb begin
    state_nxt = tmo ? ST_IDLE : fsm_nxt;
    err_next  = fault | tmo;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      timer <= '0;
    end else begin
      state <= state_nxt;
      if ((TIMEOUT_CYCLES != 0) && (state_nxt == state) && (state != ST_IDLE))
        timer <= timer + 1'b1;
      else
        timer <= '0;
    end
  end

endmodule

// File: rtl/parking_occupancy_ctrl.sv
// rtl/parking_occupancy_ctrl.sv - multi-gate occupancy counter with saturating clamp and sticky errors
module parking_occupancy_ctrl
  import parking_pkg::*;
#(
  parameter int NUM_GATES      = 2,
  parameter int CAPACITY       = 99,
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int CNT_W          = bits_for(CAPACITY)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_GATES-1:0] a,
  input  logic [NUM_GATES-1:0] b,
  input  logic                 clr_err,
  output logic [NUM_GATES-1:0] enter_pulse,
  output logic [NUM_GATES-1:0] exit_pulse,
  output logic [NUM_GATES-1:0] gate_err,
  output logic [CNT_W-1:0]     count,
  output logic                 full,
  output logic                 empty,
  output logic                 overflow_err,
  output logic                 underflow_err
);

  localparam int NET_W = CNT_W + bits_for(NUM_GATES) + 1;
  localparam logic signed [NET_W-1:0] CAP_S = NET_W'(CAPACITY);

  logic [NUM_GATES-1:0]     enter_next;
  logic [NUM_GATES-1:0]     exit_next;
  logic [NUM_GATES-1:0]     err_next;
  logic [NET_W-1:0]         ent_cnt;
  logic [NET_W-1:0]         ext_cnt;
  logic signed [NET_W-1:0]  raw;
  logic [CNT_W-1:0]         count_nxt;
  logic                     ovf_set;
  logic                     unf_set;

  for (genvar g = 0; g < NUM_GATES; g++) begin : g_gate
    gate_dir_fsm #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_fsm (
      .clk       (clk),
      .reset     (reset),
      .a         (a[g]),
      .b         (b[g]),
      .enter_next(enter_next[g]),
      .exit_next (exit_next[g]),
      .err_next  (err_next[g])
    );
  end

  always_comb begin
    ent_cnt = '0;
    ext_cnt = '0;
    for (int g = 0; g < NUM_GATES; g++) begin
      ent_cnt = ent_cnt + NET_W'(enter_next[g]);
      ext_cnt = ext_cnt + NET_W'(exit_next[g]);
    end
  end

  // Entries and exits from different gates net out before the clamp is applied.
  always_comb begin
    raw       = signed'(NET_W'(count)) + signed'(ent_cnt) - signed'(ext_cnt);
    ovf_set   = 1'b0;
    unf_set   = 1'b0;
    count_nxt = raw[CNT_W-1:0];
    if (raw > CAP_S) begin
      ovf_set   = 1'b1;
      count_nxt = CNT_W'(CAPACITY);
    end else if (raw < 0) begin
      unf_set   = 1'b1;
      count_nxt = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      enter_pulse   <= '0;
      exit_pulse    <= '0;
      gate_err      <= '0;
      count         <= '0;
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      enter_pulse   <= enter_next;
      exit_pulse    <= exit_next;
      gate_err      <= err_next;
      count         <= count_nxt;
      overflow_err  <= ovf_set | (overflow_err & ~clr_err);
      underflow_err <= unf_set | (underflow_err & ~clr_err);
    end
  end

  assign full  = (count == CNT_W'(CAPACITY));
  assign empty = (count == '0);

endmodule

// File: tb/tb_parking_occupancy_ctrl.sv
// tb/tb_parking_occupancy_ctrl.sv - scoreboard bench for parking_occupancy_ctrl
module tb_parking_occupancy_ctrl;

  localparam int NG  = 2;
  localparam int CAP = 3;
  localparam int TMO = 8;
  localparam int CW  = 2;

  localparam logic [1:0] N  = 2'b00;
  localparam logic [1:0] B  = 2'b01;
  localparam logic [1:0] A  = 2'b10;
  localparam logic [1:0] AB = 2'b11;

  typedef struct packed {
    logic [1:0]    ent;
    logic [1:0]    ext;
    logic [1:0]    err;
    logic [CW-1:0] cnt;
    logic          full;
    logic          empty;
    logic          ovf;
    logic          unf;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NG-1:0] a = '0;
  logic [NG-1:0] b = '0;
  logic          clr_err = 1'b0;
  logic [NG-1:0] enter_pulse;
  logic [NG-1:0] exit_pulse;
  logic [NG-1:0] gate_err;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  logic          overflow_err;
  logic          underflow_err;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;

  parking_occupancy_ctrl #(
    .NUM_GATES     (NG),
    .CAPACITY      (CAP),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .a            (a),
    .b            (b),
    .clr_err      (clr_err),
    .enter_pulse  (enter_pulse),
    .exit_pulse   (exit_pulse),
    .gate_err     (gate_err),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .overflow_err (overflow_err),
    .underflow_err(underflow_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  task automatic push(input logic [1:0] ent, input logic [1:0] ext, input logic [1:0] err,
                      input int cnt, input logic fl, input logic em, input logic ovf, input logic unf);
    exp_t e;
    e.ent = ent; e.ext = ext; e.err = err; e.cnt = CW'(cnt);
    e.full = fl; e.empty = em; e.ovf = ovf; e.unf = unf;
    exp_q.push_back(e);
  endtask

  // Apply {a,b} per gate just after a rising edge and hold for n edges.
  task automatic drive(input logic [1:0] ab0, input logic [1:0] ab1, input int n);
    a = {ab1[1], ab0[1]};
    b = {ab1[0], ab0[0]};
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    @(posedge clk);
    #1;
    clr_err = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    exp_t got;
    forever begin
      @(negedge clk);
      if (!reset && ((enter_pulse | exit_pulse | gate_err) != '0)) begin
        got = '{enter_pulse, exit_pulse, gate_err, count, full, empty, overflow_err, underflow_err};
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event: got ent=%b ext=%b err=%b cnt=%0d, required no event",
                   enter_pulse, exit_pulse, gate_err, count);
        end else begin
          e = exp_q.pop_front();
          if (got != e) begin
            n_fail++;
            $display("FAIL event: got ent=%b ext=%b err=%b cnt=%0d full=%b empty=%b ovf=%b unf=%b, required ent=%b ext=%b err=%b cnt=%0d full=%b empty=%b ovf=%b unf=%b",
                     got.ent, got.ext, got.err, got.cnt, got.full, got.empty, got.ovf, got.unf,
                     e.ent, e.ext, e.err, e.cnt, e.full, e.empty, e.ovf, e.unf);
          end
        end
      end
    end
  end

  initial begin : stim
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_count", int'(count), 0);
    chk("reset_empty", int'(empty), 1);
    chk("reset_full", int'(full), 0);
    chk("reset_pulses", int'({enter_pulse, exit_pulse, gate_err}), 0);
    chk("reset_flags", int'({overflow_err, underflow_err}), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Entry on gate 0
    drive(A, N, 3); drive(AB, N, 3); drive(B, N, 3);
    push(2'b01, 2'b00, 2'b00, 1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(N, N, 3);

    // Exit on gate 1
    drive(N, B, 3); drive(N, AB, 3); drive(N, A, 3);
    push(2'b00, 2'b10, 2'b00, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(N, N, 3);

    // Balk and back-out produce nothing
    drive(A, N, 3); drive(N, N, 3);
    drive(A, N, 3); drive(AB, N, 3); drive(A, N, 3); drive(N, N, 3);
    chk("balk_count", int'(count), 0);
    chk("balk_empty", int'(empty), 1);

    // Illegal 10 -> 01
    drive(A, N, 3);
    push(2'b00, 2'b00, 2'b01, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(B, N, 3); drive(N, N, 3);

    // Stuck in EN_AB until timeout; trailing 01 -> 00 must not complete an entry
    drive(A, N, 3);
    push(2'b00, 2'b00, 2'b01, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(AB, N, 12); drive(B, N, 3); drive(N, N, 3);

    // Exit at count 0 underflows
    drive(N, B, 3); drive(N, AB, 3); drive(N, A, 3);
    push(2'b00, 2'b10, 2'b00, 0, 1'b0, 1'b1, 1'b0, 1'b1);
    drive(N, N, 3);
    pulse_clr();
    chk("unf_cleared", int'(underflow_err), 0);

    // Two simultaneous entries, then one more to reach capacity
    drive(A, A, 3); drive(AB, AB, 3); drive(B, B, 3);
    push(2'b11, 2'b00, 2'b00, 2, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(N, N, 3);
    drive(A, N, 3); drive(AB, N, 3); drive(B, N, 3);
    push(2'b01, 2'b00, 2'b00, 3, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(N, N, 3);

    // Two entries at capacity overflow
    drive(A, A, 3); drive(AB, AB, 3); drive(B, B, 3);
    push(2'b11, 2'b00, 2'b00, 3, 1'b1, 1'b0, 1'b1, 1'b0);
    drive(N, N, 3);
    chk("ovf_sticky", int'(overflow_err), 1);
    pulse_clr();
    chk("ovf_cleared", int'(overflow_err), 0);

    // Entry and exit together at capacity net to zero
    drive(A, B, 3); drive(AB, AB, 3); drive(B, A, 3);
    push(2'b01, 2'b10, 2'b00, 3, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(N, N, 3);
    chk("net_count", int'(count), 3);

    // Asynchronous reset mid-sequence
    drive(A, N, 3); drive(AB, N, 2);
    #3;
    reset = 1'b1;
    #1;
    chk("midrst_count", int'(count), 0);
    chk("midrst_empty", int'(empty), 1);
    chk("midrst_full", int'(full), 0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    drive(B, N, 3); drive(N, N, 3);

    repeat (3) @(posedge clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
